traffic_light_controller: RTL and testbench

Fixed-time traffic light controller for a T-junction with a two-way main road (M1, M2), a protected main-road turn (MT) and a side road (S). A single Moore state machine cycles through six phases, each held for a parameterised number of clock cycles, and drives one-hot red/yellow/green lamp codes for the four signal heads. It sits at the top of the intersection logic and takes no inputs other than clock and reset.

---
 rtl/traffic_light_controller.sv | 105 ++++++++++
 tb/tb_traffic_light_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_controller
//  Purpose  : Fixed-time Moore controller for a T-junction with heads
//             M1, M2 (main road), MT (protected main turn) and S (side road).
//             Six timed phases S1..S6. When TLC_ALL_RED_EN is defined, an
//             all-red clearance phase AR sits between S6 and S1.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_controller #(
  parameter int T_MAIN   = 7,
  parameter int T_YEL    = 2,
  parameter int T_TURN   = 5,
  parameter int T_SIDE   = 3,
  parameter int T_ALLRED = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2
);

  // Lamp codes, one-hot {green, yellow, red}
  localparam logic [2:0] C_RED = 3'b001;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b100;

  // The counter only reaches duration-1, so clog2 of the longest phase is
  // enough bits. T_ALLRED is always included so the width does not depend
  // on the build option. A floor of 4 bits is kept.
  localparam int C_MAX_AB  = (T_MAIN > T_YEL) ? T_MAIN : T_YEL;
  localparam int C_MAX_CD  = (T_TURN > T_SIDE) ? T_TURN : T_SIDE;
  localparam int C_MAX_ABC = (C_MAX_AB > C_MAX_CD) ? C_MAX_AB : C_MAX_CD;
  localparam int C_MAX_T   = (C_MAX_ABC > T_ALLRED) ? C_MAX_ABC : T_ALLRED;
  localparam int C_CW      = ($clog2(C_MAX_T) < 4) ? 4 : $clog2(C_MAX_T);

`ifdef TLC_ALL_RED_EN
  typedef enum logic [2:0] {
    S1 = 3'd0, S2 = 3'd1, S3 = 3'd2, S4 = 3'd3, S5 = 3'd4, S6 = 3'd5, AR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S1 = 3'd0, S2 = 3'd1, S3 = 3'd2, S4 = 3'd3, S5 = 3'd4, S6 = 3'd5
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [C_CW-1:0]   r_cnt;
  logic [C_CW-1:0]   w_last_cnt;

  // Phase length (as final counter value) and successor of the current state
  always_comb begin
    w_last_cnt = C_CW'(T_MAIN - 1);
    w_next     = S1;
    case (r_state)
      S1: begin w_last_cnt = C_CW'(T_MAIN - 1); w_next = S2; end
      S2: begin w_last_cnt = C_CW'(T_YEL - 1);  w_next = S3; end
      S3: begin w_last_cnt = C_CW'(T_TURN - 1); w_next = S4; end
      S4: begin w_last_cnt = C_CW'(T_YEL - 1);  w_next = S5; end
      S5: begin w_last_cnt = C_CW'(T_SIDE - 1); w_next = S6; end
`ifdef TLC_ALL_RED_EN
      S6: begin w_last_cnt = C_CW'(T_YEL - 1);    w_next = AR; end
      AR: begin w_last_cnt = C_CW'(T_ALLRED - 1); w_next = S1; end
`else
      S6: begin w_last_cnt = C_CW'(T_YEL - 1);  w_next = S1; end
`endif
      default: begin w_last_cnt = '0; w_next = S1; end
    endcase
  end

  // State and phase counter: counter restarts at 0 on every state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S1;
      r_cnt   <= '0;
    end else if (r_cnt == w_last_cnt) begin
      r_state <= w_next;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Moore lamp decode straight from the state register; unknown codes go red
  always_comb begin
    light_M1 = C_RED;
    light_M2 = C_RED;
    light_MT = C_RED;
    light_S  = C_RED;
    case (r_state)
      S1: begin light_M1 = C_GRN; light_M2 = C_GRN; end
      S2: begin light_M1 = C_GRN; light_M2 = C_YEL; end
      S3: begin light_M1 = C_GRN; light_MT = C_GRN; end
      S4: begin light_M1 = C_YEL; light_MT = C_YEL; end
      S5: begin light_S  = C_GRN; end
      S6: begin light_S  = C_YEL; end
      default: begin end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_controller
//  Purpose  : Directed self-checking bench. Instantiates the default build
//             and a short-timing build (T_MAIN=3, T_YEL=1, T_TURN=2,
//             T_SIDE=1) and compares every sampled lamp set against a
//             hand-written phase table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_controller;

  // Expected lamps {M1, M2, MT, S} per phase: S1..S6, AR
  localparam logic [11:0] P_S1 = {3'b100, 3'b100, 3'b001, 3'b001};
  localparam logic [11:0] P_S2 = {3'b100, 3'b010, 3'b001, 3'b001};
  localparam logic [11:0] P_S3 = {3'b100, 3'b001, 3'b100, 3'b001};
  localparam logic [11:0] P_S4 = {3'b010, 3'b001, 3'b010, 3'b001};
  localparam logic [11:0] P_S5 = {3'b001, 3'b001, 3'b001, 3'b100};
  localparam logic [11:0] P_S6 = {3'b001, 3'b001, 3'b001, 3'b010};
  localparam logic [11:0] P_AR = {3'b001, 3'b001, 3'b001, 3'b001};

`ifdef TLC_ALL_RED_EN
  localparam int AR_LEN = 1;
`else
  localparam int AR_LEN = 0;
`endif
  localparam int PER_A = 21 + AR_LEN;  // default timings
  localparam int PER_B = 9 + AR_LEN;   // short timings

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] a_m1, a_m2, a_mt, a_s;
  logic [2:0] b_m1, b_m2, b_mt, b_s;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_light_controller dut_a (
    .clk(clk), .rst(rst),
    .light_M1(a_m1), .light_S(a_s), .light_MT(a_mt), .light_M2(a_m2)
  );

  traffic_light_controller #(
    .T_MAIN(3), .T_YEL(1), .T_TURN(2), .T_SIDE(1), .T_ALLRED(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .light_M1(b_m1), .light_S(b_s), .light_MT(b_mt), .light_M2(b_m2)
  );

  // Expected lamps at position pos (0 = sample right after the reset edge)
  function automatic logic [11:0] expect_at(int pos, int tm, int ty, int tt, int ts);
    int p;
    int per;
    per = tm + ty + tt + ty + ts + ty + AR_LEN;
    p = pos % per;
    if (p < tm) return P_S1;
    p -= tm;
    if (p < ty) return P_S2;
    p -= ty;
    if (p < tt) return P_S3;
    p -= tt;
    if (p < ty) return P_S4;
    p -= ty;
    if (p < ts) return P_S5;
    p -= ts;
    if (p < ty) return P_S6;
    return P_AR;
  endfunction

  function automatic bit one_hot3(logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Pulse reset across one rising edge; returns at the following negedge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({a_m1, a_m2, a_mt, a_s} !== P_S1) begin
        failures++;
        $display("FAIL reset_hold_a[%0d] got=%b exp=%b", i, {a_m1, a_m2, a_mt, a_s}, P_S1);
      end
      checks++;
      if ({b_m1, b_m2, b_mt, b_s} !== P_S1) begin
        failures++;
        $display("FAIL reset_hold_b[%0d] got=%b exp=%b", i, {b_m1, b_m2, b_mt, b_s}, P_S1);
      end
    end
    rst = 1'b0;
  endtask

  // Full period plus wrap back to S1 for the default build
  task automatic test_full_cycle();
    logic [11:0] e;
    do_reset();
    for (int pos = 0; pos <= PER_A; pos++) begin
      e = expect_at(pos, 7, 2, 5, 3);
      checks++;
      if ({a_m1, a_m2, a_mt, a_s} !== e) begin
        failures++;
        $display("FAIL full_cycle pos=%0d got=%b exp=%b", pos, {a_m1, a_m2, a_mt, a_s}, e);
      end
      @(negedge clk);
    end
  endtask

  // 100 cycles: phase table, one-hot lamps and safety invariants on both DUTs
  task automatic test_long_run();
    logic [11:0] e;
    bit ok;
    do_reset();
    for (int pos = 0; pos < 100; pos++) begin
      e = expect_at(pos, 7, 2, 5, 3);
      checks++;
      if ({a_m1, a_m2, a_mt, a_s} !== e) begin
        failures++;
        $display("FAIL long_run pos=%0d got=%b exp=%b", pos, {a_m1, a_m2, a_mt, a_s}, e);
      end
      ok = one_hot3(a_m1) && one_hot3(a_m2) && one_hot3(a_mt) && one_hot3(a_s)
        && one_hot3(b_m1) && one_hot3(b_m2) && one_hot3(b_mt) && one_hot3(b_s);
      ok = ok && !(a_s != 3'b001 && (a_m1 != 3'b001 || a_m2 != 3'b001 || a_mt != 3'b001));
      ok = ok && !(b_s != 3'b001 && (b_m1 != 3'b001 || b_m2 != 3'b001 || b_mt != 3'b001));
      ok = ok && !(a_m2 != 3'b001 && a_mt != 3'b001);
      ok = ok && !(b_m2 != 3'b001 && b_mt != 3'b001);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL invariants pos=%0d got_a=%b got_b=%b exp=onehot_and_safe",
                 pos, {a_m1, a_m2, a_mt, a_s}, {b_m1, b_m2, b_mt, b_s});
      end
      @(negedge clk);
    end
  endtask

  // Reset pulsed mid-S4 must jump straight to a full-length S1
  task automatic test_reset_mid_yellow();
    logic [11:0] e;
    do_reset();
    repeat (15) @(negedge clk);  // position 15 = second cycle of S4
    checks++;
    if ({a_m1, a_m2, a_mt, a_s} !== P_S4) begin
      failures++;
      $display("FAIL pre_reset_s4 got=%b exp=%b", {a_m1, a_m2, a_mt, a_s}, P_S4);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int pos = 0; pos <= 7; pos++) begin
      e = (pos < 7) ? P_S1 : P_S2;
      checks++;
      if ({a_m1, a_m2, a_mt, a_s} !== e) begin
        failures++;
        $display("FAIL mid_reset pos=%0d got=%b exp=%b", pos, {a_m1, a_m2, a_mt, a_s}, e);
      end
      @(negedge clk);
    end
  endtask

  // Short-timing build: two periods plus the wrap
  task automatic test_params();
    logic [11:0] e;
    do_reset();
    for (int pos = 0; pos <= 2 * PER_B; pos++) begin
      e = expect_at(pos, 3, 1, 2, 1);
      checks++;
      if ({b_m1, b_m2, b_mt, b_s} !== e) begin
        failures++;
        $display("FAIL params pos=%0d got=%b exp=%b", pos, {b_m1, b_m2, b_mt, b_s}, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_long_run();
    test_reset_mid_yellow();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
